demux_1to2_reg: RTL and testbench
=================================

Name: demux_1to2_reg

Overview:
- Registered 1-to-2 demultiplexer; the inverse of the team's 2:1 word mux.
- Routes one input word stream to output channel 0 or 1 under control of sel.
- Uses valid/ready handshakes, with a one-entry holding register per output channel.
- Sits between a single producer and two consumers in the lab datapath.

Parameters:
- N, 2, MSB index of the data word (word width N+1 = 3 bits).
- CNT_W, 4, width of each per-channel transfer counter (used only when DEMUX_CNT_EN is defined).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  N+1  input word
- in_sel  input  1  destination: 0 routes to channel 0, 1 routes to channel 1
- in_valid  input  1  producer has a word
- in_ready  output  1  block can accept the word this cycle
- out0_data  output  N+1  channel 0 word
- out0_valid  output  1  channel 0 holds a word
- out0_ready  input  1  channel 0 consumer accepts
- out1_data  output  N+1  channel 1 word
- out1_valid  output  1  channel 1 holds a word
- out1_ready  input  1  channel 1 consumer accepts
- cnt0  output  CNT_W  channel 0 completed transfers (DEMUX_CNT_EN only)
- cnt1  output  CNT_W  channel 1 completed transfers (DEMUX_CNT_EN only)

Behaviour:
- Reset (rst_n low, asynchronous):
  - outK_valid=0, outK_data=0, cntK=0.
  - in_ready follows its combinational equation, so it reads 1 while reset is held.
- Per-channel state machine, states EMPTY and FULL:
  - EMPTY -> FULL on accept to that channel.
  - FULL -> EMPTY when outK_ready=1 and no simultaneous accept to that channel.
  - FULL -> FULL when outK_ready=1 and an accept arrives in the same cycle; the register reloads with the new word.
  - FULL -> FULL (holding) when outK_ready=0.
- outK_valid is 1 exactly in FULL.
- in_ready (combinational) = EMPTY(sel) OR outK_ready(sel), where K = in_sel.
  - Ready depends only on the selected channel.
  - A stalled channel never blocks words bound for the other channel.
- Accept condition: in_valid AND in_ready at a rising edge.
- Latency: an accepted word appears on outK_data/outK_valid one cycle after acceptance.
- in_sel is sampled only at the accept edge. The producer may change in_sel while stalled; in_ready re-evaluates the same cycle.
- Data stability:
  - outK_data changes only on an accept to channel K.
  - outK_data holds its last value after the word drains (it is not zeroed).
  - The unselected channel's data is never disturbed.
- Full throughput: one word per cycle is sustained to a single channel when its consumer holds ready=1. Alternating sel also sustains one word per cycle.
- Simultaneous events:
  - Drain of channel 0 and accept to channel 1 in the same cycle proceed independently.
  - Both channels may drain in the same cycle.
- Reset mid-operation: held words are discarded, with no output glitch beyond valid falling.

Optional Feature:
- Macro: DEMUX_CNT_EN.
- Defined:
  - cnt0/cnt1 ports exist.
  - cntK increments by 1 on every completed output handshake (outK_valid AND outK_ready).
  - Counters wrap from 2^CNT_W-1 to 0 without saturation.
  - Counters reset to 0.
- Undefined: the cnt ports and counter logic are absent; all other behaviour is identical.

Decomposition:
- Package demux_pkg:
  - default word width constant (N=2);
  - channel index constants CH0=0, CH1=1;
  - state encoding EMPTY=0, FULL=1.
- Sub-module demux_out_stage:
  - one instance per channel;
  - contains the EMPTY/FULL state machine, data register and optional counter;
  - inputs load/data/ready; outputs valid/data/count.
- The top level contains only the in_ready logic and the routing of the load strobe.

Test Plan:
- Reset: assert rst_n=0 mid-run with both channels FULL -> out0_valid=out1_valid=0, out0_data=out1_data=000, cnt0=cnt1=0 immediately.
- Basic routing: in_data=011, sel=1, valid=1, out1_ready=1 -> next cycle out1_data=011, out1_valid=1; out0_valid stays 0 and out0_data unchanged.
- Backpressure isolation:
  - hold out0_ready=0 and send 110 to ch0 -> ch0 FULL;
  - then with sel=0 -> in_ready=0;
  - switch sel=1 with 100 -> in_ready=1, out1_data=100 next cycle, out0_data still 110.
- Stream throughput: 6 back-to-back words 000,011,010,000,110,111 with sel alternating 0,1,0,1,1,0 and both readies 1 -> each word appears one cycle later on the correct channel, no stalls.
- Simultaneous reload: ch0 FULL with 010, out0_ready=1, accept 111 to ch0 in the same cycle -> out0_valid stays 1, out0_data=111 next cycle.
- Counter wrap (DEMUX_CNT_EN, CNT_W=4): 17 handshakes on ch1 -> cnt1 reads 15 after the 15th, 0 after the 16th, 1 after the 17th; cnt0 stays 0.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and types for the registered 1-to-2 demultiplexer.
// Optional per-channel transfer counters are enabled with DEMUX_CNT_EN.
package demux_pkg;

    // Default MSB index of the data word (word width N_DEFAULT+1).
    localparam int N_DEFAULT = 2;

    // Channel indices as seen on in_sel.
    localparam logic CH0 = 1'b0;
    localparam logic CH1 = 1'b1;

    // Per-channel holding register occupancy.
    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } stage_state_t;

endpackage : demux_pkg

// File: rtl/demux_out_stage.sv
// One output channel of the demux: a one-entry holding register with a
// valid/ready handshake toward its consumer.
// With DEMUX_CNT_EN defined, a wrapping counter of completed handshakes
// is also kept.
module demux_out_stage
    import demux_pkg::*;
#(
    parameter int W = N_DEFAULT + 1
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W = 4
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic [W-1:0]     i_data,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [W-1:0]     o_data
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] o_count
`endif
);

    stage_state_t r_state;
    stage_state_t w_next_state;
    logic [W-1:0] r_data;

    // State register for the EMPTY/FULL occupancy machine.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is always updated with <= so every register
        // samples pre-edge values regardless of block ordering.
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state: a load always leaves the stage FULL (fresh or reloaded);
    // otherwise a held word drains when the consumer is ready.
    always_comb begin
        // NOTE: default assigned first so no path leaves w_next_state
        // unassigned, which would infer a latch.
        w_next_state = r_state;
        case (r_state)
            EMPTY: if (i_load) w_next_state = FULL;
            FULL: begin
                if (i_load)       w_next_state = FULL;
                else if (i_ready) w_next_state = EMPTY;
            end
            default: w_next_state = EMPTY;
        endcase
    end

    // Data register: changes only on a load, keeps its value after draining.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: this datapath register is reset because the output word is
        // required to read zero while reset is held.
        if (!rst_n) begin
            r_data <= '0;
        end else if (i_load) begin
            r_data <= i_data;
        end
    end

    assign o_valid = (r_state == FULL);
    assign o_data  = r_data;

`ifdef DEMUX_CNT_EN
    logic [CNT_W-1:0] r_count;

    // Count completed output handshakes; wraps naturally at 2^CNT_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (o_valid && i_ready) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
`endif

endmodule : demux_out_stage

// File: rtl/demux_1to2_reg.sv
// Registered 1-to-2 demultiplexer with valid/ready handshakes.
// in_sel steers each accepted word into one of two one-entry output stages;
// readiness depends only on the selected stage, so a stalled channel never
// blocks traffic bound for the other one.
// Optional: define DEMUX_CNT_EN to add per-channel transfer counters.
module demux_1to2_reg
    import demux_pkg::*;
#(
    parameter int N = N_DEFAULT
`ifdef DEMUX_CNT_EN
    ,
    parameter int CNT_W = 4
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N:0]       in_data,
    input  logic             in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [N:0]       out0_data,
    output logic             out0_valid,
    input  logic             out0_ready,
    output logic [N:0]       out1_data,
    output logic             out1_valid,
    input  logic             out1_ready
`ifdef DEMUX_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    logic w_ready0;
    logic w_ready1;
    logic w_accept;
    logic w_load0;
    logic w_load1;

    // A channel can take a word if it is empty or is draining this cycle.
    assign w_ready0 = !out0_valid || out0_ready;
    assign w_ready1 = !out1_valid || out1_ready;
    assign in_ready = (in_sel == CH1) ? w_ready1 : w_ready0;

    // Route the accept strobe to the selected stage only.
    assign w_accept = in_valid && in_ready;
    assign w_load0  = w_accept && (in_sel == CH0);
    assign w_load1  = w_accept && (in_sel == CH1);

    demux_out_stage #(
        .W     (N + 1)
`ifdef DEMUX_CNT_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) u_stage0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load0),
        .i_data  (in_data),
        .i_ready (out0_ready),
        .o_valid (out0_valid),
        .o_data  (out0_data)
`ifdef DEMUX_CNT_EN
        ,
        .o_count (cnt0)
`endif
    );

    demux_out_stage #(
        .W     (N + 1)
`ifdef DEMUX_CNT_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) u_stage1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load1),
        .i_data  (in_data),
        .i_ready (out1_ready),
        .o_valid (out1_valid),
        .o_data  (out1_data)
`ifdef DEMUX_CNT_EN
        ,
        .o_count (cnt1)
`endif
    );

endmodule : demux_1to2_reg

// File: tb/tb_demux_1to2_reg.sv
// Self-checking bench for demux_1to2_reg: directed scenarios plus randomized
// traffic, all compared against a channel-occupancy reference model.
// Counter checks are compiled in when DEMUX_CNT_EN is defined.
module tb_demux_1to2_reg;

    logic       clk;
    logic       rst_n;
    logic [2:0] in_data;
    logic       in_sel;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] out0_data;
    logic       out0_valid;
    logic       out0_ready;
    logic [2:0] out1_data;
    logic       out1_valid;
    logic       out1_ready;
`ifdef DEMUX_CNT_EN
    logic [3:0] cnt0;
    logic [3:0] cnt1;
`endif

    demux_1to2_reg dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .out0_data  (out0_data),
        .out0_valid (out0_valid),
        .out0_ready (out0_ready),
        .out1_data  (out1_data),
        .out1_valid (out1_valid),
        .out1_ready (out1_ready)
`ifdef DEMUX_CNT_EN
        ,
        .cnt0       (cnt0),
        .cnt1       (cnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: what each channel holds and how many words it has
    // delivered to its consumer.
    bit       m_full [2];
    bit [2:0] m_data [2];
    int       m_done [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_full[k] = 1'b0;
            m_data[k] = 3'b000;
            m_done[k] = 0;
        end
    endtask

    task automatic check_outputs();
        check("out0_valid", out0_valid, m_full[0]);
        check("out0_data",  out0_data,  m_data[0]);
        check("out1_valid", out1_valid, m_full[1]);
        check("out1_data",  out1_data,  m_data[1]);
`ifdef DEMUX_CNT_EN
        check("cnt0", cnt0, m_done[0] % 16);
        check("cnt1", cnt1, m_done[1] % 16);
`endif
    endtask

    // One clock of traffic: drive inputs, check readiness, advance the model
    // across the rising edge, then check every output.
    task automatic step(input logic v, input logic s, input logic [2:0] d,
                        input logic r0, input logic r1);
        bit rdy [2];
        bit exp_ready;
        bit accept;
        in_valid   = v;
        in_sel     = s;
        in_data    = d;
        out0_ready = r0;
        out1_ready = r1;
        #1;
        rdy[0]    = r0;
        rdy[1]    = r1;
        exp_ready = !m_full[s] || rdy[s];
        check("in_ready", in_ready, exp_ready);
        accept = v && exp_ready;
        for (int k = 0; k < 2; k++) begin
            if (m_full[k] && rdy[k]) m_done[k]++;
            if (accept && (int'(s) == k)) begin
                m_full[k] = 1'b1;
                m_data[k] = d;
            end else if (rdy[k]) begin
                m_full[k] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        check("in_ready_rst", in_ready, 1'b1);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    bit [2:0] stream_d [6] = '{3'b000, 3'b011, 3'b010, 3'b000, 3'b110, 3'b111};
    bit       stream_s [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        rst_n      = 1'b0;
        in_data    = '0;
        in_sel     = 1'b0;
        in_valid   = 1'b0;
        out0_ready = 1'b0;
        out1_ready = 1'b0;
        model_reset();
        #2;
        do_reset();

        // Basic routing to channel 1; channel 0 untouched.
        step(1'b1, 1'b1, 3'b011, 1'b0, 1'b1);
        check("route_out1_data", out1_data, 3'b011);
        check("route_out0_valid", out0_valid, 1'b0);
        step(1'b0, 1'b0, 3'b000, 1'b0, 1'b1);

        // Backpressure isolation: stalled ch0 blocks only ch0 traffic.
        step(1'b1, 1'b0, 3'b110, 1'b0, 1'b1);
        step(1'b1, 1'b0, 3'b101, 1'b0, 1'b1);
        step(1'b1, 1'b1, 3'b100, 1'b0, 1'b1);
        check("iso_out1_data", out1_data, 3'b100);
        check("iso_out0_data", out0_data, 3'b110);
        step(1'b0, 1'b0, 3'b000, 1'b1, 1'b1);

        // Back-to-back stream with alternating destinations.
        for (int i = 0; i < 6; i++) begin
            step(1'b1, stream_s[i], stream_d[i], 1'b1, 1'b1);
        end
        step(1'b0, 1'b0, 3'b000, 1'b1, 1'b1);

        // Simultaneous drain and reload on channel 0.
        step(1'b1, 1'b0, 3'b010, 1'b0, 1'b0);
        step(1'b1, 1'b0, 3'b111, 1'b1, 1'b0);
        check("reload_valid", out0_valid, 1'b1);
        check("reload_data", out0_data, 3'b111);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom), 1'($urandom), 3'($urandom),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end

        // Reset mid-run with both channels holding nonzero words.
        step(1'b1, 1'b0, 3'b101, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'b110, 1'b0, 1'b0);
        #2;
        do_reset();

`ifdef DEMUX_CNT_EN
        // Counter wrap on channel 1: step j completes j-1 handshakes.
        for (int j = 1; j <= 18; j++) begin
            step(1'b1, 1'b1, 3'($urandom), 1'b0, 1'b1);
            if (j == 16) check("cnt1_wrap15", cnt1, 4'd15);
            if (j == 17) check("cnt1_wrap0",  cnt1, 4'd0);
            if (j == 18) check("cnt1_wrap1",  cnt1, 4'd1);
        end
        check("cnt0_idle", cnt0, 4'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_demux_1to2_reg
